// File: rtl/tensor_register_sequencer.sv
// Command-driven sequencer that streams bytes into, or out of, a bank of 8-bit registers.
// Define TENSOR_SEQ_OVERRUN_CHECK_EN to reject commands that run past the last register (adds the error output).
module tensor_register_sequencer #(
   parameter int NUM_REGS   = 16,
   parameter int ADDR_WIDTH = 4
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic                  cmd_write,
   input  logic [ADDR_WIDTH-1:0] cmd_base,
   input  logic [ADDR_WIDTH:0]   cmd_count,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [7:0]            in_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [7:0]            out_data,
   output logic [NUM_REGS-1:0]   reg_enable,
   output logic                  reg_write_or_read,
   output logic [7:0]            reg_write_data,
   input  logic [7:0]            reg_read_data,
   output logic                  busy,
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
   output logic                  error,
`endif
   output logic                  done
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DRAIN = 2'd3
   } state_t;

   localparam logic [ADDR_WIDTH-1:0] ADDR_ZERO  = {ADDR_WIDTH{1'b0}};
   localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
   localparam logic [ADDR_WIDTH:0]   COUNT_ZERO = {(ADDR_WIDTH+1){1'b0}};
   localparam logic [ADDR_WIDTH:0]   COUNT_ONE  = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [NUM_REGS-1:0]   ENABLE_ONE = {{(NUM_REGS-1){1'b0}}, 1'b1};

   state_t                state_r, state_s;
   logic [ADDR_WIDTH-1:0] addr_r, addr_s;
   logic [ADDR_WIDTH:0]   remaining_r, remaining_s;
   logic                  out_valid_r, out_valid_s;
   logic [7:0]            out_data_r, out_data_s;
   logic                  done_r, done_s;
   logic                  issue_s;
   logic                  last_s;
   logic [NUM_REGS-1:0]   addr_onehot_s;

`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
   localparam logic [ADDR_WIDTH+1:0] REGS_LIMIT = (ADDR_WIDTH+2)'(NUM_REGS);
   logic                  error_r, error_s;
   logic [ADDR_WIDTH+1:0] span_s;
   logic                  overrun_s;

   assign span_s    = {2'b00, cmd_base} + {1'b0, cmd_count};
   assign overrun_s = (span_s > REGS_LIMIT);
   assign error     = error_r;
`endif

   // A read byte may issue when the output slot is empty or being emptied this cycle.
   assign issue_s       = (!out_valid_r) || out_ready;
   assign last_s        = (remaining_r == COUNT_ONE);
   assign addr_onehot_s = ENABLE_ONE << addr_r;

   assign out_valid = out_valid_r;
   assign out_data  = out_data_r;
   assign done      = done_r;

   // Next-state, bank strobes and handshake outputs.
   always_comb begin
      state_s           = state_r;
      addr_s            = addr_r;
      remaining_s       = remaining_r;
      out_valid_s       = out_valid_r;
      out_data_s        = out_data_r;
      done_s            = 1'b0;
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
      error_s           = 1'b0;
`endif
      cmd_ready         = 1'b0;
      in_ready          = 1'b0;
      busy              = 1'b1;
      reg_enable        = {NUM_REGS{1'b0}};
      reg_write_or_read = 1'b0;
      reg_write_data    = 8'h00;

      case (state_r)
         ST_IDLE: begin
            cmd_ready = 1'b1;
            busy      = 1'b0;
            if (cmd_valid) begin
               addr_s      = cmd_base;
               remaining_s = cmd_count;
               if (cmd_count == COUNT_ZERO) begin
                  done_s = 1'b1;
               end
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
               else if (overrun_s) begin
                  done_s  = 1'b1;
                  error_s = 1'b1;
               end
`endif
               else if (cmd_write) begin
                  state_s = ST_WRITE;
               end else begin
                  state_s = ST_READ;
               end
            end else begin
               state_s = ST_IDLE;
            end
         end

         ST_WRITE: begin
            in_ready = 1'b1;
            if (in_valid) begin
               reg_enable        = addr_onehot_s;
               reg_write_or_read = 1'b1;
               reg_write_data    = in_data;
               addr_s            = addr_r + ADDR_ONE;
               remaining_s       = remaining_r - COUNT_ONE;
               if (last_s) begin
                  state_s = ST_IDLE;
                  done_s  = 1'b1;
               end else begin
                  state_s = ST_WRITE;
               end
            end else begin
               state_s = ST_WRITE;
            end
         end

         ST_READ: begin
            if (issue_s) begin
               reg_enable  = addr_onehot_s;
               out_data_s  = reg_read_data;
               out_valid_s = 1'b1;
               addr_s      = addr_r + ADDR_ONE;
               remaining_s = remaining_r - COUNT_ONE;
               if (last_s) begin
                  state_s = ST_DRAIN;
               end else begin
                  state_s = ST_READ;
               end
            end else begin
               state_s = ST_READ;
            end
         end

         ST_DRAIN: begin
            if (out_ready) begin
               out_valid_s = 1'b0;
               state_s     = ST_IDLE;
               done_s      = 1'b1;
            end else begin
               state_s = ST_DRAIN;
            end
         end

         default: begin
            state_s     = ST_IDLE;
            addr_s      = ADDR_ZERO;
            remaining_s = COUNT_ZERO;
            out_valid_s = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset aborts any command in flight.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_r     <= ST_IDLE;
         addr_r      <= ADDR_ZERO;
         remaining_r <= COUNT_ZERO;
         out_valid_r <= 1'b0;
         out_data_r  <= 8'h00;
         done_r      <= 1'b0;
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
         error_r     <= 1'b0;
`endif
      end else begin
         state_r     <= state_s;
         addr_r      <= addr_s;
         remaining_r <= remaining_s;
         out_valid_r <= out_valid_s;
         out_data_r  <= out_data_s;
         done_r      <= done_s;
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
         error_r     <= error_s;
`endif
      end
   end

endmodule

// File: tb/tb_tensor_register_sequencer.sv
// Scoreboard bench for tensor_register_sequencer with a behavioural 16-entry register bank.
module tb_tensor_register_sequencer;

   localparam int NUM_REGS   = 16;
   localparam int ADDR_WIDTH = 4;

   logic                  clock = 1'b0;
   logic                  reset_n;
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_WIDTH-1:0] cmd_base;
   logic [ADDR_WIDTH:0]   cmd_count;
   logic                  in_valid;
   logic                  in_ready;
   logic [7:0]            in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [7:0]            out_data;
   logic [NUM_REGS-1:0]   reg_enable;
   logic                  reg_write_or_read;
   logic [7:0]            reg_write_data;
   logic [7:0]            reg_read_data;
   logic                  busy;
   logic                  done;
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
   logic                  error;
`endif

   int checks = 0;
   int errors = 0;

   logic [24:0] en_q[$];
   logic [7:0]  data_q[$];
   logic [7:0]  shadow [NUM_REGS];
   logic [7:0]  bank [NUM_REGS];

   tensor_register_sequencer #(
      .NUM_REGS  (NUM_REGS),
      .ADDR_WIDTH(ADDR_WIDTH)
   ) dut (
      .clock            (clock),
      .reset_n          (reset_n),
      .cmd_valid        (cmd_valid),
      .cmd_ready        (cmd_ready),
      .cmd_write        (cmd_write),
      .cmd_base         (cmd_base),
      .cmd_count        (cmd_count),
      .in_valid         (in_valid),
      .in_ready         (in_ready),
      .in_data          (in_data),
      .out_valid        (out_valid),
      .out_ready        (out_ready),
      .out_data         (out_data),
      .reg_enable       (reg_enable),
      .reg_write_or_read(reg_write_or_read),
      .reg_write_data   (reg_write_data),
      .reg_read_data    (reg_read_data),
      .busy             (busy),
`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
      .error            (error),
`endif
      .done             (done)
   );

   always #5 clock = ~clock;

   // Register bank: captures on enabled write, drives read_data only when enabled for read.
   always @(posedge clock) begin
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reg_enable[i] && reg_write_or_read) bank[i] <= reg_write_data;
      end
   end

   always_comb begin
      reg_read_data = 8'h00;
      for (int i = 0; i < NUM_REGS; i++) begin
         if (reg_enable[i] && !reg_write_or_read) reg_read_data = reg_read_data | bank[i];
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      if (obs !== exp_v) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   // Monitor: bank accesses and delivered bytes checked against the scoreboards.
   initial begin
      logic       stalled;
      logic [7:0] stall_data;
      logic [24:0] exp_acc;
      stalled    = 1'b0;
      stall_data = 8'h00;
      forever begin
         @(negedge clock);
         #2;
         if (reset_n) begin
            check_eq("onehot_enable", 32'($onehot0(reg_enable)), 32'd1);
            if (reg_enable != 16'h0000) begin
               if (en_q.size() == 0) begin
                  check_eq("unexpected_access", {reg_write_or_read, reg_write_data, reg_enable}, 32'h0);
               end else begin
                  exp_acc = en_q.pop_front();
                  check_eq("reg_access", {reg_write_or_read, reg_write_data, reg_enable}, exp_acc);
               end
            end
            if (stalled && out_valid) check_eq("stall_hold", out_data, stall_data);
            if (out_valid && out_ready) begin
               if (data_q.size() == 0) check_eq("extra_byte", out_data, 32'hDEAD_BEEF);
               else check_eq("out_data", out_data, data_q.pop_front());
            end
            stalled    = out_valid && !out_ready;
            stall_data = out_data;
         end else begin
            stalled = 1'b0;
         end
      end
   end

   task automatic wait_idle();
      int n = 0;
      while (!cmd_ready && n < 50) begin
         @(negedge clock);
         n++;
      end
      check_eq("cmd_ready_wait", cmd_ready, 32'd1);
   endtask

   task automatic do_write(input logic [3:0] base, input int count, input logic [7:0] seed,
                           input logic [7:0] step, input int nbytes, input bit gaps);
      logic [7:0]  bytes [32];
      logic [3:0]  a;
      logic [15:0] one = 16'h0001;
      wait_idle();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_base  = base;
      cmd_count = count[4:0];
      bytes[0]  = seed;
      for (int k = 0; k < nbytes; k++) begin
         if (k > 0) bytes[k] = bytes[k-1] + step;
         a = base + k[3:0];
         en_q.push_back({1'b1, bytes[k], one << a});
         shadow[a] = bytes[k];
      end
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int k = 0; k < nbytes; k++) begin
         check_eq("in_ready", in_ready, 32'd1);
         in_valid = 1'b1;
         in_data  = bytes[k];
         @(negedge clock);
         in_valid = 1'b0;
         if (gaps && k < nbytes - 1) @(negedge clock);
      end
      in_valid = 1'b0;
      in_data  = 8'h00;
      if (nbytes == count) begin
         check_eq("write_done", done, 32'd1);
         check_eq("write_busy", busy, 32'd0);
         @(negedge clock);
         check_eq("write_done_pulse", done, 32'd0);
      end
   endtask

   task automatic do_read(input logic [3:0] base, input int count, input bit toggle);
      logic [3:0]  a;
      logic [15:0] one = 16'h0001;
      int          vcnt = 0;
      bit          finished = 1'b0;
      wait_idle();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_base  = base;
      cmd_count = count[4:0];
      for (int k = 0; k < count; k++) begin
         a = base + k[3:0];
         en_q.push_back({1'b0, 8'h00, one << a});
         data_q.push_back(shadow[a]);
      end
      @(negedge clock);
      cmd_valid = 1'b0;
      for (int c = 0; c < 100 && !finished; c++) begin
         if (done) begin
            finished = 1'b1;
         end else begin
            if (out_valid) vcnt++;
            out_ready = toggle ? c[0] : 1'b1;
            @(negedge clock);
         end
      end
      out_ready = 1'b0;
      check_eq("read_done", finished, 32'd1);
      if (!toggle) check_eq("valid_cycles", vcnt, count);
      check_eq("bytes_left", data_q.size(), 32'd0);
      check_eq("access_left", en_q.size(), 32'd0);
   endtask

   initial begin
      reset_n   = 1'b0;
      cmd_valid = 1'b0;
      cmd_write = 1'b0;
      cmd_base  = 4'h0;
      cmd_count = 5'd0;
      in_valid  = 1'b0;
      in_data   = 8'h00;
      out_ready = 1'b0;
      repeat (2) @(negedge clock);
      check_eq("rst_cmd_ready", cmd_ready, 32'd1);
      check_eq("rst_outputs", {busy, in_ready, out_valid, out_data, done}, 32'h0);
      check_eq("rst_bank_if", {reg_enable, reg_write_or_read, reg_write_data}, 32'h0);
      reset_n = 1'b1;
      @(negedge clock);

      do_write(4'd0, 4, 8'h11, 8'h11, 4, 1'b0);

      // zero-length command: done only, no bank traffic
      wait_idle();
      cmd_valid = 1'b1;
      cmd_write = 1'b0;
      cmd_base  = 4'd5;
      cmd_count = 5'd0;
      @(negedge clock);
      cmd_valid = 1'b0;
      check_eq("zero_done", done, 32'd1);
      check_eq("zero_cmd_ready", cmd_ready, 32'd1);
      check_eq("zero_busy", busy, 32'd0);
      @(negedge clock);
      check_eq("zero_done_pulse", done, 32'd0);

      do_read(4'd0, 4, 1'b0);

      // reset after 2 of 4 write bytes
      do_write(4'd0, 4, 8'hA0, 8'h01, 2, 1'b0);
      reset_n = 1'b0;
      #1;
      check_eq("abort_cmd_ready", cmd_ready, 32'd1);
      check_eq("abort_outputs", {busy, in_ready, out_valid, out_data, done}, 32'h0);
      check_eq("abort_bank_if", {reg_enable, reg_write_or_read, reg_write_data}, 32'h0);
      @(negedge clock);
      reset_n = 1'b1;
      @(negedge clock);
      do_read(4'd0, 4, 1'b0);

`ifdef TENSOR_SEQ_OVERRUN_CHECK_EN
      wait_idle();
      cmd_valid = 1'b1;
      cmd_write = 1'b1;
      cmd_base  = 4'd14;
      cmd_count = 5'd4;
      in_valid  = 1'b1;
      in_data   = 8'hFF;
      @(negedge clock);
      cmd_valid = 1'b0;
      check_eq("overrun_flags", {error, done, busy}, 32'h6);
      @(negedge clock);
      in_valid = 1'b0;
      check_eq("overrun_pulse", {error, done, busy}, 32'h0);
      do_write(4'd12, 4, 8'hC1, 8'h05, 4, 1'b1);
      do_read(4'd12, 4, 1'b1);
`else
      do_write(4'd14, 4, 8'h51, 8'h13, 4, 1'b1);
      do_read(4'd14, 4, 1'b1);
      do_write(4'd3, 20, 8'h60, 8'h07, 20, 1'b0);
      do_read(4'd0, 16, 1'b0);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/tensor_register_sequencer.md
Name: tensor_register_sequencer

Overview:
- Command-driven sequencer between the tensor core's byte-stream ports and its bank of 8-bit registers.
- Each register has a clock, write_or_read, enable, 8-bit write_data and 8-bit read_data; read_data is 0 unless that register is enabled with write_or_read=0.
- Write command: streams bytes into consecutive registers (upstream of the bank).
- Read command: drives read strobes and streams captured bytes out (downstream of the bank).

Parameters:
- NUM_REGS, 16, number of 8-bit registers in the bank; power of two, ≥2.
- ADDR_WIDTH, 4, register index width; must equal log2(NUM_REGS).

Ports:
- clock  input  1  rising-edge clock for all state
- reset_n  input  1  asynchronous, active-low reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  high only in IDLE
- cmd_write  input  1  1 = load bank from in_*, 0 = read bank to out_*
- cmd_base  input  ADDR_WIDTH  first register index
- cmd_count  input  ADDR_WIDTH+1  number of registers to access (0..2*NUM_REGS-1)
- in_valid  input  1  write byte present
- in_ready  output  1  sequencer accepts write byte
- in_data  input  8  write byte
- out_valid  output  1  read byte present
- out_ready  input  1  consumer accepts read byte
- out_data  output  8  read byte
- reg_enable  output  NUM_REGS  one-hot register enable, or all zero
- reg_write_or_read  output  1  1 = write, 0 = read; drives every register
- reg_write_data  output  8  byte to write; drives every register
- reg_read_data  input  8  bitwise OR of all registers' read_data
- busy  output  1  state != IDLE
- done  output  1  one-cycle pulse when a command completes

Behaviour:
- Reset values (async, reset_n=0): state IDLE; addr=0; remaining=0; out_valid=0; out_data=0; done=0.
- Reset combinational outputs: reg_enable=0, reg_write_or_read=0, reg_write_data=0, in_ready=0, cmd_ready=1, busy=0.
- Reset mid-command aborts the command immediately. Register contents are not touched.
- States: IDLE, WRITE, READ, DRAIN.
- IDLE, cmd_valid && cmd_ready: latch addr=cmd_base and remaining=cmd_count.
  - cmd_count=0: stay IDLE and pulse done next cycle.
  - Otherwise: go to WRITE if cmd_write=1, else READ.
- WRITE:
  - in_ready=1.
  - On in_valid: reg_enable[addr]=1, reg_write_or_read=1, reg_write_data=in_data, all combinational in the same cycle, so the register captures at that edge.
  - Each accepted byte: addr <= addr+1 mod NUM_REGS; remaining <= remaining-1.
  - Last byte (remaining=1): go to IDLE and pulse done.
  - in_valid=0: reg_enable=0; nothing changes.
- READ:
  - Issue condition: out_valid=0 or out_ready=1.
  - When the condition holds: reg_enable[addr]=1, reg_write_or_read=0, and out_data <= reg_read_data at the edge. Zero-latency read; a new byte can issue every cycle under continuous out_ready.
  - Each issue: addr wraps mod NUM_REGS; remaining decrements; out_valid <= 1.
  - Last issue: go to DRAIN.
  - Condition false: reg_enable=0 and out_data holds.
- DRAIN: hold out_valid until out_ready, then clear out_valid, go to IDLE and pulse done.
- out_valid/out_data handshake:
  - out_data is stable while out_valid=1 && out_ready=0.
  - out_valid falls only after acceptance, when no new issue occurs.
- Never more than one reg_enable bit high.
- reg_write_data=0 whenever not writing.
- in_ready=0 outside WRITE.
- Wrap-around: base+count beyond NUM_REGS continues from index 0. A count above NUM_REGS revisits registers; later writes win.
- done and cmd_ready may both be high in the cycle after completion; a new command may be accepted that cycle.

Optional Feature:
- Macro: TENSOR_SEQ_OVERRUN_CHECK_EN.
- Defined:
  - Extra output error (1 bit, reset 0).
  - A command with cmd_base+cmd_count > NUM_REGS is accepted but not executed: no register access, state stays IDLE, error and done both pulse for one cycle.
- Undefined: no error port; addresses wrap as above.

Test Plan:
- Reset with reset_n=0 mid-WRITE (after 2 of 4 bytes) -> all outputs at reset values asynchronously; registers 0,1 hold the written bytes and registers 2,3 are untouched.
- Write base=0 count=4, bytes 0x11,0x22,0x33,0x44 with continuous in_valid -> reg_enable 0x0001,0x0002,0x0004,0x0008 on consecutive cycles; done pulses 1 cycle after the last byte.
- Read base=0 count=4 with out_ready=1 -> out_data 0x11,0x22,0x33,0x44 on consecutive cycles, out_valid 4 cycles, then done.
- Read base=14 count=4, NUM_REGS=16, with out_ready toggling 1/0 -> addresses 14,15,0,1; no byte lost or duplicated; out_data stable while stalled.
- cmd_count=0 -> no reg_enable activity; done pulses once; cmd_ready stays 1.
- With TENSOR_SEQ_OVERRUN_CHECK_EN: write base=14 count=4 -> error=1 and done=1 for one cycle; reg_enable stays 0.
